// File: rtl/pattern_stream_ctrl.sv
// Purpose : frame controller counting '010' bit patterns across a stream of 32-bit words.
// Latency : result valid the cycle after the last word is accepted; 1 word/clk throughput.
// Backpressure: in_ready only in RUN; the result is held in DONE until res_ready.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start, i_num_words  frame start pulse and length (0 = empty frame), sampled in IDLE
//   i_abort               drop the current frame, return to IDLE
//   i_in_valid/o_in_ready/i_in_data     input word stream
//   o_res_valid/i_res_ready             result handshake
//   o_res_count, o_res_sat              saturating frame total and sticky saturation flag
//   o_busy                              controller not in IDLE
module pattern_stream_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  parameter int LEN_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_num_words,
  input  logic              i_abort,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [CNT_W-1:0]  o_res_count,
  output logic              o_res_sat,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Sum is wide enough for both the accumulator and a full 6-bit increment,
  // so narrow CNT_W builds still detect overflow correctly.
  localparam int              SUM_W   = ((CNT_W > 6) ? CNT_W : 6) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_acc;
  logic               r_sat;
  logic [1:0]         r_prev;
  logic               r_first;

  logic               w_beat;
  logic               w_last;
  logic               w_start_ok;
  logic [5:0]         w_inc;
  logic [SUM_W-1:0]   w_sum;
  logic               w_ovf;
  logic [CNT_W-1:0]   w_acc_nxt;
  logic [LEN_W-1:0]   w_cnt_inc;

  // A beat in the abort cycle is dropped, so abort gates acceptance.
  assign w_beat     = (r_state == RUN) && i_in_valid && !i_abort;
  assign w_start_ok = (r_state == IDLE) && i_start && !i_abort;
  assign w_cnt_inc  = r_cnt + LEN_W'(1);
  assign w_last     = w_beat && (w_cnt_inc == r_len);

  // Per-word increment: 30 windows inside the word plus, after the first
  // word, the two windows that straddle the previous word's top bits.
  always_comb begin
    w_inc = 6'd0;
    for (int i = 0; i < DATA_W - 2; i++) begin
      if (i_in_data[i +: 3] == 3'b010) begin
        w_inc = w_inc + 6'd1;
      end
    end
    if (!r_first) begin
      if ({i_in_data[0], r_prev[1:0]} == 3'b010) begin
        w_inc = w_inc + 6'd1;
      end
      if ({i_in_data[1:0], r_prev[1]} == 3'b010) begin
        w_inc = w_inc + 6'd1;
      end
    end
  end

  assign w_sum     = SUM_W'(r_acc) + SUM_W'(w_inc);
  assign w_ovf     = (w_sum > SUM_W'(CNT_MAX));
  assign w_acc_nxt = w_ovf ? CNT_MAX : w_sum[CNT_W-1:0];

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = (i_num_words == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (i_res_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (i_abort) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath. The accumulator is deliberately left alone on abort and on
  // result hand-off so res_count shows the last result until the next start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len   <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_sat   <= 1'b0;
      r_prev  <= 2'b00;
      r_first <= 1'b0;
    end else if (w_start_ok) begin
      r_len   <= i_num_words;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_sat   <= 1'b0;
      r_first <= 1'b1;
    end else if (w_beat) begin
      r_cnt   <= w_cnt_inc;
      r_acc   <= w_acc_nxt;
      r_sat   <= r_sat | w_ovf;
      r_prev  <= i_in_data[DATA_W-1 -: 2];
      r_first <= 1'b0;
    end
  end

  assign o_in_ready  = (r_state == RUN);
  assign o_res_valid = (r_state == DONE);
  assign o_res_count = r_acc;
  assign o_res_sat   = r_sat;
  assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_pattern_stream_ctrl.sv
// Directed bench for pattern_stream_ctrl: a 16-bit total instance and a 4-bit
// total instance run in lockstep on the same stimulus.
module tb_pattern_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  num_words = 8'd0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        res_ready = 1'b0;

  logic        in_ready, res_valid, res_sat, busy;
  logic [15:0] res_count;
  logic        in_ready2, res_valid2, res_sat2, busy2;
  logic [3:0]  res_count2;

  int checks = 0;
  int failures = 0;

  pattern_stream_ctrl #(.DATA_W(32), .CNT_W(16), .LEN_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_num_words(num_words),
    .i_abort(abort), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_data(in_data), .o_res_valid(res_valid), .i_res_ready(res_ready),
    .o_res_count(res_count), .o_res_sat(res_sat), .o_busy(busy)
  );

  pattern_stream_ctrl #(.DATA_W(32), .CNT_W(4), .LEN_W(8)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_num_words(num_words),
    .i_abort(abort), .i_in_valid(in_valid), .o_in_ready(in_ready2),
    .i_in_data(in_data), .o_res_valid(res_valid2), .i_res_ready(res_ready),
    .o_res_count(res_count2), .o_res_sat(res_sat2), .o_busy(busy2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [7:0] n);
    start     = 1'b1;
    num_words = n;
    step();
    start     = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input int gaps);
    in_valid = 1'b0;
    repeat (gaps) step();
    chk("in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [15:0] cnt, input logic sat);
    chk({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
    chk({tag, "_count"}, {16'd0, res_count}, {16'd0, cnt});
    chk({tag, "_sat"},   {31'd0, res_sat},   {31'd0, sat});
  endtask

  task automatic ack();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("ack_valid_drop", {31'd0, res_valid}, 32'd0);
    chk("ack_busy_drop",  {31'd0, busy},      32'd0);
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_count", {16'd0, res_count}, 32'd0);
    chk("rst_res_sat",   {31'd0, res_sat},   32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    rst_n = 1'b1;
    step();

    // 1: single '010' at bit 0; result valid one clock after the beat
    start_frame(8'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    send_word(32'h0000_0002, 0);
    expect_result("t1", 16'd1, 1'b0);
    ack();
    chk("t1_count_kept", {16'd0, res_count}, 32'd1);

    // 2: alternating bits, 15 internal windows
    start_frame(8'd1);
    send_word(32'hAAAA_AAAA, 0);
    expect_result("t2", 16'd15, 1'b0);
    ack();

    // 3: boundary window across words, and no boundary on the first word
    start_frame(8'd2);
    send_word(32'h8000_0000, 0);
    send_word(32'h0000_0000, 0);
    expect_result("t3a", 16'd1, 1'b0);
    ack();
    start_frame(8'd1);
    send_word(32'h0000_0001, 0);
    expect_result("t3b", 16'd0, 1'b0);
    ack();

    // 4: input gaps, then result backpressure
    start_frame(8'd3);
    for (int w = 0; w < 3; w++) begin
      send_word(32'hAAAA_AAAA, int'($urandom_range(0, 3)));
    end
    expect_result("t4", 16'd47, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t4_hold_valid", {31'd0, res_valid}, 32'd1);
      chk("t4_hold_count", {16'd0, res_count}, 32'd47);
    end
    ack();

    // 5: saturation on the 4-bit instance; a start pulse mid-frame is ignored
    start_frame(8'd2);
    send_word(32'hAAAA_AAAA, 0);
    start     = 1'b1;
    num_words = 8'd9;
    step();
    start     = 1'b0;
    chk("t5_still_run", {31'd0, in_ready}, 32'd1);
    send_word(32'hAAAA_AAAA, 0);
    expect_result("t5_w16", 16'd31, 1'b0);
    chk("t5_w4_valid", {31'd0, res_valid2}, 32'd1);
    chk("t5_w4_count", {28'd0, res_count2}, 32'd15);
    chk("t5_w4_sat",   {31'd0, res_sat2},   32'd1);
    ack();

    // 6a: abort after one of three words; beat in the abort cycle is dropped
    start_frame(8'd3);
    send_word(32'hAAAA_AAAA, 0);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hAAAA_AAAA;
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    chk("t6_abort_busy",  {31'd0, busy},      32'd0);
    chk("t6_abort_ready", {31'd0, in_ready},  32'd0);
    chk("t6_abort_valid", {31'd0, res_valid}, 32'd0);
    // empty frame: straight to DONE with a cleared total and flag
    start_frame(8'd0);
    expect_result("t6_empty", 16'd0, 1'b0);
    chk("t6_empty_w4_sat", {31'd0, res_sat2}, 32'd0);
    ack();
    // abort and start together: start is dropped
    start     = 1'b1;
    abort     = 1'b1;
    num_words = 8'd1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("t6_abort_start_busy", {31'd0, busy}, 32'd0);
    // the next frame starts clean
    start_frame(8'd1);
    send_word(32'h0000_0002, 0);
    expect_result("t6_after_abort", 16'd1, 1'b0);
    ack();

    // 6b: reset pulsed mid-frame
    start_frame(8'd3);
    send_word(32'hAAAA_AAAA, 0);
    rst_n = 1'b0;
    #2;
    chk("t6r_busy",  {31'd0, busy},      32'd0);
    chk("t6r_ready", {31'd0, in_ready},  32'd0);
    chk("t6r_count", {16'd0, res_count}, 32'd0);
    rst_n = 1'b1;
    step();
    start_frame(8'd0);
    expect_result("t6r_empty", 16'd0, 1'b0);
    ack();
    start_frame(8'd1);
    send_word(32'h0000_0001, 0);
    expect_result("t6r_after", 16'd0, 1'b0);
    ack();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
